// File: rtl/latch_snapshot_buf_pkg.sv
// ============================================================================
//  latch_snapshot_buf_pkg : display mode codes and width helper
//  Revision : 1.0
// ============================================================================
`default_nettype none

package latch_snapshot_buf_pkg;

  localparam logic MODE_LIVE = 1'b0;
  localparam logic MODE_HIST = 1'b1;

  // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_scan_mux.sv
// ============================================================================
//  digit_scan_mux : prescaled one-hot digit scan for the seven-segment stage
//  Revision : 1.0
// ============================================================================
`default_nettype none

module digit_scan_mux
  import latch_snapshot_buf_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIGIT_W  = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS*DIGIT_W-1:0] bus,
  output logic [DIGIT_W-1:0]        scan_digit,
  output logic [DIGITS-1:0]         scan_sel
);

  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(DIGITS);

  logic [PRE_W-1:0]   pre;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] digits [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign digits[g] = bus[g*DIGIT_W +: DIGIT_W];
  end

  // scan_sel and scan_digit are registered together so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      scan_sel   <= DIGITS'(1);
      scan_digit <= '0;
    end else begin
      if (pre == PRE_W'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
      scan_sel   <= DIGITS'(1) << idx;
      scan_digit <= digits[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/latch_snapshot_buf.sv
// ============================================================================
//  latch_snapshot_buf : live display latch plus lock-edge snapshot history
//  Revision : 1.0
// ============================================================================
`default_nettype none

module latch_snapshot_buf
  import latch_snapshot_buf_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIGIT_W  = 4,
  parameter int DEPTH    = 4,
  parameter int SCAN_DIV = 1000,
  localparam int W       = DIGITS * DIGIT_W,
  localparam int PTR_W   = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       count,
  input  logic               lock,
  input  logic               mode,
  input  logic [PTR_W-1:0]   rd_sel,
  input  logic               clear,
  output logic [W-1:0]       out_bus,
  output logic               out_valid,
  output logic [PTR_W:0]     fill,
  output logic               ovf,
  output logic [DIGIT_W-1:0] scan_digit,
  output logic [DIGITS-1:0]  scan_sel
);

  localparam logic [PTR_W:0] FILL_MAX = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     live;
  logic             lock_q;
  logic [W-1:0]     hist [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  logic             cap;
  logic             cap_eff;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W:0]   fill_nxt;
  logic             ovf_nxt;
  logic [PTR_W-1:0] rd_idx;
  logic [W-1:0]     hist_rd;
  logic             hist_hit;

  assign cap     = lock & ~lock_q;
  assign cap_eff = cap & ~clear;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    fill_nxt   = fill;
    ovf_nxt    = ovf;
    if (clear) begin
      wr_ptr_nxt = '0;
      fill_nxt   = '0;
      ovf_nxt    = 1'b0;
    end else if (cap) begin
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (fill == FILL_MAX) ovf_nxt = 1'b1;
      else                  fill_nxt = fill + (PTR_W + 1)'(1);
    end
  end

  // History reads use post-capture pointers; the slot being written is
  // bypassed from count so a same-cycle capture is visible immediately.
  always_comb begin
    rd_idx   = wr_ptr_nxt - PTR_W'(1) - rd_sel;
    hist_rd  = (cap_eff && (rd_idx == wr_ptr)) ? count : hist[rd_idx];
    hist_hit = ({1'b0, rd_sel} < fill_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live      <= '0;
      lock_q    <= 1'b1;
      wr_ptr    <= '0;
      fill      <= '0;
      ovf       <= 1'b0;
      out_bus   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      lock_q <= lock;
      if (!lock) live <= count;
      wr_ptr <= wr_ptr_nxt;
      fill   <= fill_nxt;
      ovf    <= ovf_nxt;
      if (cap_eff) hist[wr_ptr] <= count;
      case (mode)
        MODE_LIVE: begin
          out_bus   <= live;
          out_valid <= 1'b1;
        end
        MODE_HIST: begin
          out_bus   <= hist_hit ? hist_rd : '0;
          out_valid <= hist_hit;
        end
      endcase
    end
  end

  digit_scan_mux #(
    .DIGITS   (DIGITS),
    .DIGIT_W  (DIGIT_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .bus        (out_bus),
    .scan_digit (scan_digit),
    .scan_sel   (scan_sel)
  );

endmodule

`default_nettype wire
